// File: rtl/word_unpack_64to32.sv
// Unpacks a 64-bit result word into two 32-bit beats with valid/ready handshakes on both sides.
// Optionally sends a word whose upper half is zero as a single lo beat.
module word_unpack_64to32 #(
    parameter bit LO_FIRST     = 1'b1,
    parameter bit SKIP_ZERO_HI = 1'b0
) (
    input  logic        clock,
    input  logic        clr_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_hi,
    output logic        out_last
);

    // state   | meaning
    // IDLE    | no word held, waiting for an input accept
    // FIRST   | presenting the first beat of the held word
    // SECOND  | presenting the final beat; next word may load on the same edge
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_hold;
    logic [63:0] w_hold_nxt;
    logic        w_single;
    logic        w_in_ready;
    logic        w_last_xfer;

    assign w_single = SKIP_ZERO_HI && (r_hold[63:32] == 32'h0);

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_hold  <= 64'h0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_in_ready  = 1'b0;
        w_last_xfer = 1'b0;
        out_valid   = 1'b0;
        out_data    = 32'h0;
        out_hi      = 1'b0;
        out_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_FIRST;
                    w_hold_nxt  = in_data;
                end
            end
            ST_FIRST: begin
                out_valid = 1'b1;
                if (w_single) begin
                    // A zero upper half is dropped; the lo word goes out alone as the last beat.
                    out_data    = r_hold[31:0];
                    out_last    = 1'b1;
                    w_in_ready  = out_ready;
                    w_last_xfer = out_ready;
                end else begin
                    out_data = LO_FIRST ? r_hold[31:0] : r_hold[63:32];
                    out_hi   = !LO_FIRST;
                    if (out_ready) begin
                        w_state_nxt = ST_SECOND;
                    end
                end
            end
            ST_SECOND: begin
                out_valid   = 1'b1;
                out_data    = LO_FIRST ? r_hold[63:32] : r_hold[31:0];
                out_hi      = LO_FIRST;
                out_last    = 1'b1;
                w_in_ready  = out_ready;
                w_last_xfer = out_ready;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Final beat leaving: reload without a bubble if a new word is offered.
        if (w_last_xfer) begin
            if (in_valid) begin
                w_state_nxt = ST_FIRST;
                w_hold_nxt  = in_data;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign in_ready = w_in_ready & clr_n;

endmodule

// File: tb/tb_word_unpack_64to32.sv
// Self-checking bench for word_unpack_64to32: directed vector table, hand-written corner
// sequences and a randomized run against a beat-queue reference model, over three parameter sets.
module tb_word_unpack_64to32;

    logic             clock;
    logic             clr_n;
    logic [2:0]       iv;
    logic [2:0]       ir;
    logic [2:0][63:0] id;
    logic [2:0]       ov;
    logic [2:0]       ordy;
    logic [2:0][31:0] od;
    logic [2:0]       oh;
    logic [2:0]       ol;

    int n_chk;
    int n_err;

    // instance 0: lo first, no skip; 1: lo first, skip; 2: hi first, skip
    word_unpack_64to32 #(.LO_FIRST(1'b1), .SKIP_ZERO_HI(1'b0)) u_dut0 (
        .clock(clock), .clr_n(clr_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_hi(oh[0]), .out_last(ol[0]));
    word_unpack_64to32 #(.LO_FIRST(1'b1), .SKIP_ZERO_HI(1'b1)) u_dut1 (
        .clock(clock), .clr_n(clr_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_hi(oh[1]), .out_last(ol[1]));
    word_unpack_64to32 #(.LO_FIRST(1'b0), .SKIP_ZERO_HI(1'b1)) u_dut2 (
        .clock(clock), .clr_n(clr_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_hi(oh[2]), .out_last(ol[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        ev;
        logic [31:0] edata;
        logic        ehi;
        logic        elast;
        logic        eir;
    } vec_t;

    vec_t tv[17];

    // reference model: each accepted word becomes a list of {data, hi, last} beats
    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [33:0] q_front(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_pop(input int k);
        logic [33:0] v;
        case (k)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic q_push(input int k, input logic [33:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic push_word(input int k, input logic [63:0] d);
        bit lof;
        bit skip;
        lof  = (k != 2);
        skip = (k != 0);
        if (skip && d[63:32] == 32'h0) begin
            q_push(k, {d[31:0], 1'b0, 1'b1});
        end else if (lof) begin
            q_push(k, {d[31:0], 1'b0, 1'b0});
            q_push(k, {d[63:32], 1'b1, 1'b1});
        end else begin
            q_push(k, {d[63:32], 1'b1, 1'b0});
            q_push(k, {d[31:0], 1'b0, 1'b1});
        end
    endtask

    task automatic step(input int k, input string tag, input logic v, input logic [63:0] d,
                        input logic r, input logic ev, input logic [31:0] edata,
                        input logic ehi, input logic elast, input logic eir);
        @(negedge clock);
        iv[k]   = v;
        id[k]   = d;
        ordy[k] = r;
        #1;
        chk({tag, ".valid"},    64'(ov[k]), 64'(ev));
        chk({tag, ".data"},     64'(od[k]), 64'(edata));
        chk({tag, ".hi"},       64'(oh[k]), 64'(ehi));
        chk({tag, ".last"},     64'(ol[k]), 64'(elast));
        chk({tag, ".in_ready"}, 64'(ir[k]), 64'(eir));
    endtask

    task automatic rand_cycle(input bit drain);
        logic [2:0] acc;
        logic [2:0] xf;
        logic [33:0] f;
        int sz;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            iv[k]   = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
            id[k]   = {($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom), 32'($urandom)};
            ordy[k] = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            sz = q_size(k);
            chk($sformatf("rnd%0d.valid", k), 64'(ov[k]), 64'(sz != 0));
            chk($sformatf("rnd%0d.in_ready", k), 64'(ir[k]),
                64'((sz == 0) || (sz == 1 && ordy[k])));
            if (ov[k] && sz != 0) begin
                f = q_front(k);
                chk($sformatf("rnd%0d.beat", k), {30'h0, od[k], oh[k], ol[k]}, {30'h0, f});
            end
            acc[k] = iv[k] & ir[k];
            xf[k]  = ov[k] & ordy[k];
        end
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            if (xf[k] && q_size(k) != 0) q_pop(k);
            if (acc[k]) push_word(k, id[k]);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        clr_n = 1'b0;
        iv    = 3'b000;
        ordy  = 3'b000;
        id    = '0;

        tv[0]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 64'h1122334455667788,    1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 32'h55667788, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 32'h11223344, 1'b1, 1'b1, 1'b1};
        tv[4]  = '{1'b1, 64'hA1A2A3A4_B1B2B3B4,   1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tv[5]  = '{1'b1, 64'hC1C2C3C4_D1D2D3D4,   1'b1, 1'b1, 32'hB1B2B3B4, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 64'hC1C2C3C4_D1D2D3D4,   1'b1, 1'b1, 32'hA1A2A3A4, 1'b1, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 32'hD1D2D3D4, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 32'hC1C2C3C4, 1'b1, 1'b1, 1'b1};
        tv[9]  = '{1'b1, 64'h01234567_89ABCDEF,   1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tv[10] = '{1'b0, 64'h0,                   1'b0, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b1, 64'hFFFF0000_FFFF0000,   1'b0, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b0, 64'h0,                   1'b0, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0};
        tv[13] = '{1'b0, 64'h0,                   1'b1, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0};
        tv[14] = '{1'b0, 64'h0,                   1'b0, 1'b1, 32'h01234567, 1'b1, 1'b1, 1'b0};
        tv[15] = '{1'b0, 64'h0,                   1'b1, 1'b1, 32'h01234567, 1'b1, 1'b1, 1'b1};
        tv[16] = '{1'b0, 64'h0,                   1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clock);
        #1;
        chk("reset.in_ready", 64'(ir[0]), 64'(1'b0));
        chk("reset.valid",    64'(ov[0]), 64'(1'b0));
        @(negedge clock);
        clr_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(0, $sformatf("tv%0d", i), tv[i].iv, tv[i].d, tv[i].ordy,
                 tv[i].ev, tv[i].edata, tv[i].ehi, tv[i].elast, tv[i].eir);
        end

        // single-beat and hi-first corners
        step(1, "s1a", 1'b1, 64'h00000000_DEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
        step(1, "s1b", 1'b0, 64'h0,                 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
        step(1, "s1c", 1'b1, 64'h00000001_00000002, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
        step(1, "s1d", 1'b0, 64'h0,                 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0);
        step(1, "s1e", 1'b0, 64'h0,                 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b1, 1'b1);
        step(1, "s1f", 1'b0, 64'h0,                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
        step(2, "s2a", 1'b1, 64'hCAFE0000_00000001, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
        step(2, "s2b", 1'b0, 64'h0,                 1'b1, 1'b1, 32'hCAFE0000, 1'b1, 1'b0, 1'b0);
        step(2, "s2c", 1'b1, 64'h00000000_DEADBEEF, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b1);
        step(2, "s2d", 1'b1, 64'h00000000_00000005, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        step(2, "s2e", 1'b1, 64'h00000000_00000005, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
        step(2, "s2f", 1'b0, 64'h0,                 1'b1, 1'b1, 32'h00000005, 1'b0, 1'b1, 1'b1);
        step(2, "s2g", 1'b0, 64'h0,                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);

        // asynchronous reset while the last beat is pending
        step(0, "r0", 1'b1, 64'h99999999_77777777, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
        step(0, "r1", 1'b0, 64'h0,                 1'b1, 1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0);
        step(0, "r2", 1'b0, 64'h0,                 1'b0, 1'b1, 32'h99999999, 1'b1, 1'b1, 1'b0);
        #2;
        clr_n = 1'b0;
        #1;
        chk("rst.valid",    64'(ov[0]), 64'(1'b0));
        chk("rst.data",     64'(od[0]), 64'h0);
        chk("rst.last",     64'(ol[0]), 64'(1'b0));
        chk("rst.in_ready", 64'(ir[0]), 64'(1'b0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        clr_n = 1'b1;
        step(0, "r3", 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(0, "r4", 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // randomized run; every instance is idle after the reset above
        q0.delete();
        q1.delete();
        q2.delete();
        for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
        for (int c = 0; c < 6; c++) rand_cycle(1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain%0d.pending", k), 64'(q_size(k)), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
